// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, one-outstanding
// request/response I-SRAM fetch, and branch redirect with response squash.
module if_fetch_stage #(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h1c000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_allowin,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            inst_req,
  output logic [PC_W-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [31:0]     inst_rdata,
  output logic            if_ready_go,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [PC_W-1:0] PC_RST  = RESET_PC - PC_STEP;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [31:0]     inst_buf_q, inst_buf_d;
  logic            cancel_q, cancel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= PC_RST;
      inst_buf_q <= '0;
      cancel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inst_buf_q <= inst_buf_d;
      cancel_q   <= cancel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q || br_taken) state_d = S_REQ;
          else                      state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (br_taken || id_allowin) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Redirect outranks everything: it always retargets fetch_pc, and
  // marks any response still owed by memory as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inst_buf_d = inst_buf_q;
    cancel_d   = cancel_q;
    unique case (state_q)
      S_REQ: begin
        if (inst_addr_ok) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (br_taken) cancel_d = 1'b1;
        end
        if (br_taken) fetch_pc_d = br_target;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q || br_taken) cancel_d = 1'b0;
          else                      inst_buf_d = inst_rdata;
        end else if (br_taken) begin
          cancel_d = 1'b1;
        end
        if (br_taken) fetch_pc_d = br_target;
      end
      S_VALID: begin
        if (br_taken) fetch_pc_d = br_target;
      end
      default: ;
    endcase
  end

  always_comb begin
    inst_req    = (state_q == S_REQ) && !rst;
    inst_addr   = fetch_pc_q;
    if_pc       = req_pc_q;
    if_inst     = inst_buf_q;
    if_ready_go = (state_q == S_VALID) && !br_taken;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, backpressure,
// redirects in every state, and reset mid-fetch.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_ready_go;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .id_allowin   (id_allowin),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_ready_go  (if_ready_go),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete 0-wait fetch: request, response, present, transfer.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] w);
    chk("req_valid", 32'(inst_req), 32'd1);
    chk("req_addr", inst_addr, pc);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("wait_noreq", 32'(inst_req), 32'd0);
    inst_data_ok = 1'b1;
    inst_rdata   = w;
    tick();
    inst_data_ok = 1'b0;
    chk("present_rdy", 32'(if_ready_go), 32'd1);
    chk("present_pc", if_pc, pc);
    chk("present_inst", if_inst, w);
    id_allowin = 1'b1;
    tick();
    chk("after_xfer_rdy", 32'(if_ready_go), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    id_allowin   = 1'b1;
    br_taken     = 1'b0;
    br_target    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc", if_pc, 32'h1bfffffc);
      chk("rst_rdy", 32'(if_ready_go), 32'd0);
      chk("rst_req", 32'(inst_req), 32'd0);
      chk("rst_inst", if_inst, 32'd0);
    end
    rst = 1'b0;
    #1;

    fetch_one(32'h1c000000, 32'h02800c0c);
    fetch_one(32'h1c000004, 32'h1400000d);
    fetch_one(32'h1c000008, 32'h0010b4ae);

    // backpressure while presenting 0x1c00000c
    chk("bp_addr", inst_addr, 32'h1c00000c);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h28c00184;
    id_allowin   = 1'b0;
    tick();
    inst_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", 32'(if_ready_go), 32'd1);
      chk("bp_pc", if_pc, 32'h1c00000c);
      chk("bp_inst", if_inst, 32'h28c00184);
      chk("bp_req", 32'(inst_req), 32'd0);
      tick();
    end
    id_allowin = 1'b1;
    tick();
    chk("bp_next_addr", inst_addr, 32'h1c000010);

    // redirect while waiting for the response
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1c000100;
    #1;
    chk("wait_br_rdy", 32'(if_ready_go), 32'd0);
    tick();
    br_taken = 1'b0;
    chk("wait_br_rdy2", 32'(if_ready_go), 32'd0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hdeadbeef;
    #1;
    chk("stale_rdy", 32'(if_ready_go), 32'd0);
    tick();
    inst_data_ok = 1'b0;
    chk("stale_drop_rdy", 32'(if_ready_go), 32'd0);
    chk("stale_drop_addr", inst_addr, 32'h1c000100);
    fetch_one(32'h1c000100, 32'h50000400);

    // redirect in the same cycle the request is accepted
    chk("same_addr", inst_addr, 32'h1c000104);
    inst_addr_ok = 1'b1;
    br_taken     = 1'b1;
    br_target    = 32'h1c000100;
    tick();
    inst_addr_ok = 1'b0;
    br_taken     = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hbadc0de0;
    tick();
    inst_data_ok = 1'b0;
    chk("same_drop_rdy", 32'(if_ready_go), 32'd0);
    chk("same_next_addr", inst_addr, 32'h1c000100);

    // redirect while presenting: instruction squashed, never transferred
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h11111111;
    tick();
    inst_data_ok = 1'b0;
    chk("valid_pre_rdy", 32'(if_ready_go), 32'd1);
    br_taken  = 1'b1;
    br_target = 32'h1c000300;
    #1;
    chk("valid_br_rdy", 32'(if_ready_go), 32'd0);
    tick();
    br_taken = 1'b0;
    chk("valid_br_after", 32'(if_ready_go), 32'd0);
    chk("valid_br_addr", inst_addr, 32'h1c000300);

    // redirect in S_REQ without acceptance: address moves next cycle
    br_taken  = 1'b1;
    br_target = 32'h1c000400;
    #1;
    chk("req_br_hold", inst_addr, 32'h1c000300);
    tick();
    br_taken = 1'b0;
    chk("req_br_addr", inst_addr, 32'h1c000400);

    // reset mid-operation while waiting
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("mid_wait_pc", if_pc, 32'h1c000400);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(inst_req), 32'd0);
    chk("mid_rst_rdy", 32'(if_ready_go), 32'd0);
    chk("mid_rst_pc", if_pc, 32'h1bfffffc);
    rst = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hffffffff;
    tick();
    inst_data_ok = 1'b0;
    chk("mid_ign_rdy", 32'(if_ready_go), 32'd0);
    fetch_one(32'h1c000000, 32'h02800c0c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
